bitstream_avg: RTL and testbench

BITSTREAM_AVG -- requirements
Module: bitstream_avg

---
 rtl/bitstream_avg_pkg.sv | 17 +
 rtl/bitstream_avg_bit_window.sv | 34 +++
 rtl/bitstream_avg.sv | 101 ++++++++++
 tb/tb_bitstream_avg.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/bitstream_avg_pkg.sv
// Shared types and fixed-point helpers for the sigma-delta bitstream blocks.
package bitstream_avg_pkg;

  typedef enum logic {
    FILL   = 1'b0,
    STEADY = 1'b1
  } avg_state_e;

  // Two's-complement encoding of +1.0 or -1.0 with F = bit_width-int_width-1 fraction bits.
  function automatic logic [63:0] fxp_unit(input int bit_width, input int int_width,
                                           input logic negative);
    logic [63:0] one;
    one = 64'd1 << (bit_width - int_width - 1);
    return negative ? (~one + 64'd1) : one;
  endfunction

endpackage

// File: rtl/bitstream_avg_bit_window.sv
// DEPTH-deep bit shift register; evict is the bit that the next enabled shift discards.
module bit_window #(
  parameter int DEPTH = 64
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clr,
  input  logic en,
  input  logic d,
  output logic evict
);

  logic [DEPTH-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (clr) begin
      sr_d = '0;
    end else if (en) begin
      sr_d = {sr_q[DEPTH-2:0], d};
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign evict = sr_q[DEPTH-1];

endmodule

// File: rtl/bitstream_avg.sv
// Moving-window mean of a bipolar sigma-delta bitstream, output in signed fixed point.
// Handshake: a sample is taken on a rising CLK edge with bit_valid=1 and clear=0; no backpressure.
module bitstream_avg
  import bitstream_avg_pkg::*;
#(
  parameter int BIT_WIDTH = 16,
  parameter int INT_WIDTH = 1,
  parameter int WINDOW    = 64
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       bit_in,
  input  logic                       bit_valid,
  input  logic                       clear,
  output logic [BIT_WIDTH-1:0]       y,
  output logic                       y_valid,
  output logic [$clog2(WINDOW):0]    ones
);

  localparam int F     = BIT_WIDTH - INT_WIDTH - 1;
  localparam int L     = $clog2(WINDOW);
  localparam int OW    = L + 1;
  localparam int SHIFT = F - L;
  localparam logic [OW-1:0]        W_CNT = OW'(WINDOW);
  localparam logic [BIT_WIDTH-1:0] Y_NEG = BIT_WIDTH'(fxp_unit(BIT_WIDTH, INT_WIDTH, 1'b1));

  generate
    if (WINDOW < 2 || (WINDOW & (WINDOW - 1)) != 0) begin : g_bad_window
      $error("bitstream_avg: WINDOW must be a power of two >= 2");
    end
    if (F < L) begin : g_bad_frac
      $error("bitstream_avg: fraction bits must be >= log2(WINDOW)");
    end
    if (INT_WIDTH < 1) begin : g_bad_int
      $error("bitstream_avg: INT_WIDTH must be >= 1 so +1.0 is representable");
    end
  endgenerate

  logic                     accept;
  logic                     evict;
  logic [OW-1:0]            ones_q, ones_d;
  logic [OW-1:0]            fill_q, fill_d;
  logic [BIT_WIDTH-1:0]     y_q, y_d;
  avg_state_e               state_q, state_d;
  logic signed [OW+1:0]     centered;

  assign accept = bit_valid & ~clear;

  bit_window #(.DEPTH(WINDOW)) u_window (
    .CLK   (CLK),
    .nRST  (nRST),
    .clr   (clear),
    .en    (accept),
    .d     (bit_in),
    .evict (evict)
  );

  always_comb begin
    ones_d   = ones_q;
    fill_d   = fill_q;
    state_d  = state_q;
    y_d      = y_q;
    centered = '0;
    if (clear) begin
      ones_d  = '0;
      fill_d  = '0;
      state_d = FILL;
      y_d     = Y_NEG;
    end else if (accept) begin
      ones_d = ones_q + OW'(bit_in) - OW'(evict);
      if (fill_q != W_CNT) begin
        fill_d = fill_q + OW'(1);
      end
      if (fill_q == W_CNT - OW'(1)) begin
        state_d = STEADY;
      end
      // 2*ones - WINDOW is the bipolar sum; scaling by 2^F/WINDOW is a pure left shift.
      centered = $signed({1'b0, ones_d, 1'b0}) - $signed((OW + 2)'(WINDOW));
      y_d      = BIT_WIDTH'(centered) <<< SHIFT;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      ones_q  <= '0;
      fill_q  <= '0;
      state_q <= FILL;
      y_q     <= Y_NEG;
    end else begin
      ones_q  <= ones_d;
      fill_q  <= fill_d;
      state_q <= state_d;
      y_q     <= y_d;
    end
  end

  assign y       = y_q;
  assign y_valid = (state_q == STEADY);
  assign ones    = ones_q;

endmodule

// File: tb/tb_bitstream_avg.sv
// Directed and random checks of bitstream_avg against a sample-queue reference model.
module tb_bitstream_avg;

  logic        CLK;
  logic        nRST;
  logic        bit_in, bit_valid, clear;
  logic [15:0] y8;
  logic        yv8;
  logic [3:0]  ones8;
  logic        b64, v64, clear64;
  logic [15:0] y64;
  logic        yv64;
  logic [6:0]  ones64;

  int vectors;
  int miscompares;

  logic q8[$];
  logic q64[$];
  int   n8, n64;

  bitstream_avg #(.BIT_WIDTH(16), .INT_WIDTH(1), .WINDOW(8)) dut8 (
    .CLK(CLK), .nRST(nRST), .bit_in(bit_in), .bit_valid(bit_valid), .clear(clear),
    .y(y8), .y_valid(yv8), .ones(ones8)
  );

  bitstream_avg #(.BIT_WIDTH(16), .INT_WIDTH(1), .WINDOW(64)) dut64 (
    .CLK(CLK), .nRST(nRST), .bit_in(b64), .bit_valid(v64), .clear(clear64),
    .y(y64), .y_valid(yv64), .ones(ones64)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [15:0] y_of(input int n_ones, input int w);
    int v;
    v = ((2 * n_ones - w) * 16384) / w;
    return v[15:0];
  endfunction

  function automatic int model_ones8();
    int c = 0;
    foreach (q8[i]) c += int'(q8[i]);
    return c;
  endfunction

  function automatic int model_ones64();
    int c = 0;
    foreach (q64[i]) c += int'(q64[i]);
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check8(input string tag);
    chk({tag, "_y"},    32'(y8),    32'(y_of(model_ones8(), 8)));
    chk({tag, "_ones"}, 32'(ones8), 32'(model_ones8()));
    chk({tag, "_yv"},   32'(yv8),   32'(n8 == 8));
  endtask

  task automatic check64(input string tag);
    chk({tag, "_y"},    32'(y64),    32'(y_of(model_ones64(), 64)));
    chk({tag, "_ones"}, 32'(ones64), 32'(model_ones64()));
    chk({tag, "_yv"},   32'(yv64),   32'(n64 == 64));
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0; bit_valid = 1'b1; bit_in = 1'b1; clear = 1'b0; v64 = 1'b1; b64 = 1'b1;
    repeat (2) @(posedge CLK);
    q8.delete(); q64.delete(); n8 = 0; n64 = 0;
    #1;
    check8("rst");
    check64("rst64");
    chk("rst_y_const", 32'(y8), 32'h0000_C000);
    @(negedge CLK);
    nRST = 1'b1; bit_valid = 1'b0; v64 = 1'b0;
  endtask

  task automatic step(input logic v, input logic b, input logic c);
    @(negedge CLK);
    bit_valid = v; bit_in = b; clear = c; v64 = 1'b0;
    @(posedge CLK);
    if (c) begin
      q8.delete(); n8 = 0;
    end else if (v) begin
      q8.push_front(b);
      if (q8.size() > 8) void'(q8.pop_back());
      if (n8 < 8) n8++;
    end
    #1 check8("step");
  endtask

  task automatic step64(input logic b);
    @(negedge CLK);
    bit_valid = 1'b0; v64 = 1'b1; b64 = b;
    @(posedge CLK);
    q64.push_front(b);
    if (q64.size() > 64) void'(q64.pop_back());
    if (n64 < 64) n64++;
    #1 check64("sdm");
  endtask

  initial begin
    logic        pat [8];
    logic [15:0] exp_gap;
    int          acc, yd;
    logic        sb;
    vectors = 0; miscompares = 0; n8 = 0; n64 = 0;
    nRST = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; clear = 1'b0;
    b64 = 1'b0; v64 = 1'b0; clear64 = 1'b0;

    // All ones fills to +1.0, then two zeros step down.
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0);
    chk("ones_full_y", 32'(y8), 32'h4000);
    chk("ones_full_cnt", 32'(ones8), 32'd8);
    chk("ones_full_yv", 32'(yv8), 32'd1);
    step(1'b1, 1'b0, 1'b0);
    chk("drop1_y", 32'(y8), 32'h3000);
    step(1'b1, 1'b0, 1'b0);
    chk("drop2_y", 32'(y8), 32'h2000);
    chk("drop2_cnt", 32'(ones8), 32'd6);

    // All zeros gives -1.0; alternating pattern settles at 0.
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0);
    chk("zeros_y", 32'(y8), 32'hC000);
    chk("zeros_yv", 32'(yv8), 32'd1);
    for (int i = 0; i < 16; i++) step(1'b1, 1'((i + 1) % 2), 1'b0);
    chk("alt_y", 32'(y8), 32'h0000);

    // Gapped delivery must match back-to-back delivery.
    foreach (pat[i]) pat[i] = 1'($urandom);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, pat[i], 1'b0);
      repeat (3) step(1'b0, 1'($urandom), 1'b0);
    end
    exp_gap = y_of(model_ones8(), 8);
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, pat[i], 1'b0);
    chk("gap_vs_b2b", 32'(y8), 32'(exp_gap));

    // clear with a simultaneous sample drops it and restarts the fill.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom), 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk("clr_ones", 32'(ones8), 32'd0);
    chk("clr_y", 32'(y8), 32'hC000);
    chk("clr_yv", 32'(yv8), 32'd0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'($urandom), 1'b0);
    chk("clr_refill7_yv", 32'(yv8), 32'd0);
    step(1'b1, 1'($urandom), 1'b0);
    chk("clr_refill8_yv", 32'(yv8), 32'd1);

    // Random traffic with gaps, clears and occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 29) == 0));
    end

    // First-order modulator encoding 0.25 into the 64-sample window.
    do_reset();
    acc = 0;
    for (int i = 0; i < 200; i++) begin
      sb = (acc >= 0);
      acc += 4096 - (sb ? 16384 : -16384);
      step64(sb);
      if (n64 == 64) begin
        yd = int'($signed(y64)) - 4096;
        if (yd < 0) yd = -yd;
        chk("sdm_tol", 32'(yd <= 512), 32'd1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
